// File: rtl/gomoku_cursor_ctrl.sv
// Gomoku cursor / turn controller: moves the cursor from button pulses and issues placement requests.
// Optional CURSOR_WRAP_EN: cursor wraps at the board edges instead of saturating.
module gomoku_cursor_ctrl #(
  parameter int BOARD_N = 15,
  parameter int CW      = $clog2(BOARD_N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          up_pulse,
  input  logic          down_pulse,
  input  logic          left_pulse,
  input  logic          right_pulse,
  input  logic          place_pulse,
  input  logic          new_game_pulse,
  input  logic          game_over,
  output logic          place_req,
  output logic [CW-1:0] place_row,
  output logic [CW-1:0] place_col,
  output logic          place_player,
  input  logic          place_ack,
  input  logic          place_ok,
  output logic [CW-1:0] cursor_row,
  output logic [CW-1:0] cursor_col,
  output logic          turn,
  output logic [7:0]    move_count,
  output logic          reject_pulse
);

  localparam logic [CW-1:0] CENTER    = CW'(BOARD_N / 2);
  localparam logic [CW-1:0] MAX_C     = CW'(BOARD_N - 1);
  localparam logic [7:0]    MAX_MOVES = 8'(BOARD_N * BOARD_N);

  typedef enum logic {IDLE, REQ} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] row_reg, row_next, col_reg, col_next;
  logic [CW-1:0] prow_reg, prow_next, pcol_reg, pcol_next;
  logic          pplayer_reg, pplayer_next;
  logic          turn_reg, turn_next;
  logic [7:0]    count_reg, count_next;
  logic          reject_reg, reject_next;
  logic          pending_reg, pending_next;

  function automatic logic [CW-1:0] coord_dec(input logic [CW-1:0] v);
`ifdef CURSOR_WRAP_EN
    return (v == '0) ? MAX_C : v - CW'(1);
`else
    return (v == '0) ? v : v - CW'(1);
`endif
  endfunction

  function automatic logic [CW-1:0] coord_inc(input logic [CW-1:0] v);
`ifdef CURSOR_WRAP_EN
    return (v == MAX_C) ? '0 : v + CW'(1);
`else
    return (v == MAX_C) ? v : v + CW'(1);
`endif
  endfunction

  // Opposing pulses in the same cycle cancel.
  function automatic logic [CW-1:0] coord_move(input logic [CW-1:0] v,
                                               input logic dec, input logic inc);
    if (dec && !inc)      return coord_dec(v);
    else if (inc && !dec) return coord_inc(v);
    else                  return v;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (place_pulse && !game_over && !new_game_pulse) state_next = REQ;
      REQ:  if (place_ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    place_req    = (state_reg == REQ);
    place_row    = prow_reg;
    place_col    = pcol_reg;
    place_player = pplayer_reg;
    cursor_row   = row_reg;
    cursor_col   = col_reg;
    turn         = turn_reg;
    move_count   = count_reg;
    reject_pulse = reject_reg;
  end

  always_comb begin
    row_next     = row_reg;
    col_next     = col_reg;
    prow_next    = prow_reg;
    pcol_next    = pcol_reg;
    pplayer_next = pplayer_reg;
    turn_next    = turn_reg;
    count_next   = count_reg;
    reject_next  = 1'b0;
    pending_next = pending_reg;
    case (state_reg)
      IDLE: begin
        pending_next = 1'b0;
        if (new_game_pulse) begin
          row_next   = CENTER;
          col_next   = CENTER;
          turn_next  = 1'b0;
          count_next = '0;
        end else begin
          row_next = coord_move(row_reg, up_pulse, down_pulse);
          col_next = coord_move(col_reg, left_pulse, right_pulse);
          // Request captures the cursor as it was before any same-cycle move.
          if (place_pulse && !game_over) begin
            prow_next    = row_reg;
            pcol_next    = col_reg;
            pplayer_next = turn_reg;
          end
        end
      end
      REQ: begin
        if (new_game_pulse) pending_next = 1'b1;
        if (place_ack) begin
          if (place_ok) begin
            turn_next  = ~turn_reg;
            count_next = (count_reg >= MAX_MOVES) ? MAX_MOVES : count_reg + 8'd1;
          end else begin
            reject_next = 1'b1;
          end
          // A deferred restart lands after the outcome so its reset values win.
          if (pending_reg || new_game_pulse) begin
            row_next     = CENTER;
            col_next     = CENTER;
            turn_next    = 1'b0;
            count_next   = '0;
            pending_next = 1'b0;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_reg     <= CENTER;
      col_reg     <= CENTER;
      prow_reg    <= '0;
      pcol_reg    <= '0;
      pplayer_reg <= 1'b0;
      turn_reg    <= 1'b0;
      count_reg   <= '0;
      reject_reg  <= 1'b0;
      pending_reg <= 1'b0;
    end else begin
      row_reg     <= row_next;
      col_reg     <= col_next;
      prow_reg    <= prow_next;
      pcol_reg    <= pcol_next;
      pplayer_reg <= pplayer_next;
      turn_reg    <= turn_next;
      count_reg   <= count_next;
      reject_reg  <= reject_next;
      pending_reg <= pending_next;
    end
  end

endmodule

// File: tb/tb_gomoku_cursor_ctrl.sv
// Scoreboard bench for gomoku_cursor_ctrl: a game-level model pushes expected snapshots,
// a monitor pops and compares one per clock.
module tb_gomoku_cursor_ctrl;

  localparam int N  = 15;
  localparam int CW = $clog2(N);
  localparam int C  = N / 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          up_pulse = 0, down_pulse = 0, left_pulse = 0, right_pulse = 0;
  logic          place_pulse = 0, new_game_pulse = 0, game_over = 0;
  logic          place_ack = 0, place_ok = 0;
  logic          place_req, place_player, turn, reject_pulse;
  logic [CW-1:0] place_row, place_col, cursor_row, cursor_col;
  logic [7:0]    move_count;

  gomoku_cursor_ctrl #(.BOARD_N(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .up_pulse(up_pulse), .down_pulse(down_pulse),
    .left_pulse(left_pulse), .right_pulse(right_pulse),
    .place_pulse(place_pulse), .new_game_pulse(new_game_pulse),
    .game_over(game_over),
    .place_req(place_req), .place_row(place_row), .place_col(place_col),
    .place_player(place_player), .place_ack(place_ack), .place_ok(place_ok),
    .cursor_row(cursor_row), .cursor_col(cursor_col), .turn(turn),
    .move_count(move_count), .reject_pulse(reject_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    int row, col, count, prow, pcol;
    bit turn, req, pplayer, rej;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  // Reference model state: the game as a player would describe it.
  int m_row = C, m_col = C, m_count = 0, m_prow = 0, m_pcol = 0;
  bit m_turn = 0, m_busy = 0, m_pend = 0, m_rej = 0, m_pplayer = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int mv(input int v, input int delta);
`ifdef CURSOR_WRAP_EN
    return (v + delta + N) % N;
`else
    if (v + delta < 0)     return 0;
    if (v + delta > N - 1) return N - 1;
    return v + delta;
`endif
  endfunction

  task automatic model_reset();
    m_row = C; m_col = C; m_turn = 0; m_count = 0;
    m_busy = 0; m_pend = 0; m_rej = 0;
  endtask

  // Drive one cycle of inputs, advance the model, push the expected post-edge snapshot.
  task automatic step(input bit u, d, l, r, p, ng, go, ack, ok);
    exp_t e;
    up_pulse = u; down_pulse = d; left_pulse = l; right_pulse = r;
    place_pulse = p; new_game_pulse = ng; game_over = go;
    place_ack = ack; place_ok = ok;
    if (!rst_n) model_reset();
    else if (!m_busy) begin
      m_rej = 0;
      if (ng) begin
        m_row = C; m_col = C; m_turn = 0; m_count = 0; m_pend = 0;
      end else begin
        if (p && !go) begin
          m_busy = 1; m_prow = m_row; m_pcol = m_col; m_pplayer = m_turn;
        end
        m_row = mv(m_row, int'(d) - int'(u));
        m_col = mv(m_col, int'(r) - int'(l));
      end
    end else begin
      m_rej = 0;
      if (ng) m_pend = 1;
      if (ack) begin
        if (ok) begin
          m_turn = !m_turn;
          m_count = (m_count + 1 > N * N) ? N * N : m_count + 1;
        end else m_rej = 1;
        if (m_pend) begin
          m_row = C; m_col = C; m_turn = 0; m_count = 0; m_pend = 0;
        end
        m_busy = 0;
      end
    end
    e.row = m_row; e.col = m_col; e.count = m_count; e.turn = m_turn;
    e.req = m_busy; e.prow = m_prow; e.pcol = m_pcol; e.pplayer = m_pplayer; e.rej = m_rej;
    exp_q.push_back(e);
    @(negedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: one snapshot per clock, sampled just after the active edge.
  always begin
    @(posedge clk); #1;
    cyc++;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("cursor_row", 32'(cursor_row), 32'(mon_e.row));
      chk("cursor_col", 32'(cursor_col), 32'(mon_e.col));
      chk("turn", 32'(turn), 32'(mon_e.turn));
      chk("move_count", 32'(move_count), 32'(mon_e.count));
      chk("place_req", 32'(place_req), 32'(mon_e.req));
      chk("reject_pulse", 32'(reject_pulse), 32'(mon_e.rej));
      if (mon_e.req) begin
        chk("place_row", 32'(place_row), 32'(mon_e.prow));
        chk("place_col", 32'(place_col), 32'(mon_e.pcol));
        chk("place_player", 32'(place_player), 32'(mon_e.pplayer));
      end
    end
  end

  initial begin
    @(negedge clk); #1;
    idle(2);
    rst_n = 1'b1;
    idle(1);
    chk("reset_row", 32'(cursor_row), 7);
    chk("reset_col", 32'(cursor_col), 7);
    chk("reset_count", 32'(move_count), 0);

    // 3 up, 2 right on separate cycles
    for (int i = 0; i < 3; i++) begin step(1,0,0,0,0,0,0,0,0); idle(1); end
    for (int i = 0; i < 2; i++) begin step(0,0,0,1,0,0,0,0,0); idle(1); end
    chk("walk_row", 32'(cursor_row), 4);
    chk("walk_col", 32'(cursor_col), 9);
    chk("walk_req", 32'(place_req), 0);

    // Corner behaviour at (0,0)
    step(0,0,0,0,0,1,0,0,0);
    for (int i = 0; i < 7; i++) step(1,0,1,0,0,0,0,0,0);
    chk("corner_row", 32'(cursor_row), 0);
    step(1,0,0,0,0,0,0,0,0);
`ifdef CURSOR_WRAP_EN
    chk("edge_up_row", 32'(cursor_row), 14);
`else
    chk("edge_up_row", 32'(cursor_row), 0);
`endif
    chk("edge_up_col", 32'(cursor_col), 0);

    // up+down+right from centre
    step(0,0,0,0,0,1,0,0,0);
    step(1,1,0,1,0,0,0,0,0);
    chk("diag_row", 32'(cursor_row), 7);
    chk("diag_col", 32'(cursor_col), 8);
    step(0,0,1,0,0,0,0,0,0);

    // Accepted placement at (7,7), ack after 3 cycles
    step(0,0,0,0,1,0,0,0,0);
    chk("req_row", 32'(place_row), 7);
    idle(2);
    step(0,0,0,0,0,0,0,1,1);
    chk("ok_turn", 32'(turn), 1);
    chk("ok_count", 32'(move_count), 1);

    // Rejected placement, left ignored while requesting
    step(0,0,0,0,1,0,0,0,0);
    step(0,0,1,0,0,0,0,0,0);
    step(0,0,0,0,0,0,0,1,0);
    chk("rej_pulse", 32'(reject_pulse), 1);
    chk("rej_col", 32'(cursor_col), 7);
    chk("rej_count", 32'(move_count), 1);
    idle(1);

    // New game while requesting
    step(0,0,0,1,0,0,0,0,0);
    step(0,0,0,0,1,0,0,0,0);
    step(0,0,0,0,0,1,0,0,0);
    idle(1);
    step(0,0,0,0,0,0,0,1,1);
    chk("ng_col", 32'(cursor_col), 7);
    chk("ng_turn", 32'(turn), 0);
    chk("ng_count", 32'(move_count), 0);

    // game_over blocks placement
    step(0,0,0,0,1,0,1,0,0);
    chk("go_req", 32'(place_req), 0);

    // 226 accepted placements saturate at 225
    for (int i = 0; i < 226; i++) begin
      step(0,0,0,0,1,0,0,0,0);
      step(0,0,0,0,0,0,0,1,1);
    end
    chk("sat_count", 32'(move_count), 225);

    // Asynchronous reset in the middle of a request
    step(0,0,0,0,1,0,0,0,0);
    rst_n = 1'b0;
    #1;
    chk("arst_req", 32'(place_req), 0);
    chk("arst_count", 32'(move_count), 0);
    step(0,0,0,0,0,0,0,0,0);
    rst_n = 1'b1;
    idle(1);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 99) < 25, $urandom_range(0, 99) < 25,
           $urandom_range(0, 99) < 25, $urandom_range(0, 99) < 25,
           $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 3,
           $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 35,
           $urandom_range(0, 99) < 70);
    end

    idle(2);
    @(posedge clk); #2;
    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gomoku_cursor_ctrl.md
Name: gomoku_cursor_ctrl

Overview:
- Consumes the single-cycle debounced button pulses: up, down, left, right and place.
- Maintains the cursor position on the BOARD_N x BOARD_N board and the side to move.
- Issues stone-placement requests to the board store over a req/ack handshake.
- Sits between the per-button debouncers and the board memory / win checker.

Parameters:
- BOARD_N, 15: board edge length in cells; legal coordinates are 0..BOARD_N-1.
- CW, $clog2(BOARD_N): coordinate width (4 for BOARD_N=15).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- up_pulse, down_pulse, left_pulse, right_pulse  in  1 each  debounced one-cycle move pulses
- place_pulse  in  1  debounced one-cycle place pulse
- new_game_pulse  in  1  one-cycle request to restart the game
- game_over  in  1  level from the win checker; blocks placement while high
- place_req  out  1  placement request, held until acknowledged
- place_row, place_col  out  CW  coordinates of the requested cell, stable while place_req=1
- place_player  out  1  player to place (0=black, 1=white), stable while place_req=1
- place_ack  in  1  one-cycle acknowledge from the board store
- place_ok  in  1  valid only with place_ack; 1 = cell was empty and is now written
- cursor_row, cursor_col  out  CW  current cursor position
- turn  out  1  side to move
- move_count  out  8  number of accepted stones
- reject_pulse  out  1  one-cycle pulse on a refused placement

Behaviour:
- Reset (async assert, sync release):
  - cursor_row = cursor_col = BOARD_N/2 (7).
  - turn = 0; move_count = 0.
  - place_req = 0; reject_pulse = 0; FSM in IDLE; pending new-game flag cleared.
- FSM states: IDLE, REQ.
- IDLE:
  - A move pulse updates the cursor on the same clock edge, so the new value is visible the following cycle.
  - up decrements row, down increments row, left decrements col, right increments col.
  - up and down together leave row unchanged; left and right together leave col unchanged.
  - One vertical pulse and one horizontal pulse in the same cycle apply both (diagonal move).
  - Edge handling: see Optional Feature.
  - place_pulse with game_over=0 goes to REQ: place_req=1 next cycle; place_row/col latched from the cursor value before any same-cycle move; place_player=turn.
  - place_pulse with game_over=1 is ignored.
  - If place_pulse and a move pulse arrive together, the move is still applied to the cursor.
- REQ:
  - Move pulses and place pulses are ignored; the cursor is frozen.
  - place_req, place_row, place_col and place_player are held constant until place_ack=1 is sampled.
  - On an ack edge, return to IDLE and deassert place_req on the following cycle.
  - Ack with place_ok=1: toggle turn; increment move_count, saturating at BOARD_N*BOARD_N (225).
  - Ack with place_ok=0: reject_pulse=1 for exactly one cycle; turn and move_count unchanged.
- place_ack sampled while in IDLE is ignored, as is place_ok without place_ack.
- new_game_pulse:
  - In IDLE: cursor returns to center, turn=0, move_count=0 on that edge; overrides same-cycle move and place pulses.
  - In REQ: latched as pending. It is applied on the ack edge after the ack outcome, so the reset values win, and reject_pulse still fires if place_ok=0.
- game_over rising while in REQ does not abort the outstanding request.

Optional Feature:
- Macro: CURSOR_WRAP_EN.
- Defined: the cursor wraps at the edges; decrement from 0 gives BOARD_N-1 and increment from BOARD_N-1 gives 0.
- Undefined: the cursor saturates at 0 and BOARD_N-1; a move pulse at the edge leaves the cursor unchanged.

Test Plan:
- Reset, then 3 up_pulse and 2 right_pulse on separate cycles -> cursor (4,9); turn=0; place_req=0.
- Cursor (0,0), up_pulse -> (0,0) without the macro, (14,0) with CURSOR_WRAP_EN; same cycle up+down+right from (7,7) -> (7,8).
- place_pulse at (7,7), ack after 3 cycles with ok=1 -> place_req held 3 cycles with row=7, col=7, player=0; then turn=1, move_count=1, no reject.
- Ack with ok=0 -> reject_pulse exactly 1 cycle; turn and move_count unchanged; left_pulse during REQ leaves the cursor unchanged.
- new_game_pulse during REQ, then ack ok=1 -> after the ack edge cursor (7,7), turn=0, move_count=0.
- game_over=1, place_pulse -> no place_req; 225 accepted placements followed by one extra accepted ack -> move_count stays 225; assert rst_n mid-REQ -> place_req drops immediately and all outputs return to reset values.
